// File: rtl/branch_predict_btb_if.sv
// Fetch/resolve/flush bundle between the pipeline and the branch target buffer.
// The pipeline drives requests and outcomes; the BTB returns predictions, flush and statistics.
interface branch_predict_btb_if #(
    parameter int PC_W   = 30,
    parameter int STAT_W = 16
);
    logic              if_valid;
    logic [PC_W-1:0]   if_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_npc;

    logic              upd_valid;
    logic              upd_is_branch;
    logic [PC_W-1:0]   upd_pc;
    logic              upd_taken;
    logic [PC_W-1:0]   upd_target;
    logic              upd_pred_taken;
    logic [PC_W-1:0]   upd_pred_npc;

    logic              flush;
    logic [PC_W-1:0]   redirect_pc;
    logic [STAT_W-1:0] stat_lookups;
    logic [STAT_W-1:0] stat_mispred;

    modport master (
        output if_valid, if_pc,
        output upd_valid, upd_is_branch, upd_pc, upd_taken, upd_target,
        output upd_pred_taken, upd_pred_npc,
        input  pred_hit, pred_taken, pred_npc,
        input  flush, redirect_pc, stat_lookups, stat_mispred
    );

    modport slave (
        input  if_valid, if_pc,
        input  upd_valid, upd_is_branch, upd_pc, upd_taken, upd_target,
        input  upd_pred_taken, upd_pred_npc,
        output pred_hit, pred_taken, pred_npc,
        output flush, redirect_pc, stat_lookups, stat_mispred
    );
endinterface

// File: rtl/branch_predict_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters,
// same-cycle lookup, one-cycle table update and a registered mispredict flush.
module branch_predict_btb #(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 30,
    parameter int DYNAMIC = 1,
    parameter int STAT_W  = 16
) (
    input logic                 clk,
    input logic                 rst,
    branch_predict_btb_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W;

    logic             tbl_valid  [ENTRIES];
    logic [TAG_W-1:0] tbl_tag    [ENTRIES];
    logic [PC_W-1:0]  tbl_target [ENTRIES];
    logic [1:0]       tbl_ctr    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             lk_taken;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    logic             wr_en;
    logic             wr_valid;
    logic [TAG_W-1:0] wr_tag;
    logic [PC_W-1:0]  wr_target;
    logic [1:0]       wr_ctr;

    logic [PC_W-1:0]  cnpc;
    logic             mis;

    logic              flush_q;
    logic [PC_W-1:0]   redirect_q;
    logic [STAT_W-1:0] lookups_q;
    logic [STAT_W-1:0] mispred_q;

    // The predicted direction is implied by the predicted next PC, so it is not needed here.
    logic unused_pred_taken;
    assign unused_pred_taken = bus.upd_pred_taken;

    assign lk_idx = bus.if_pc[IDX_W-1:0];
    assign lk_tag = bus.if_pc[PC_W-1:IDX_W];
    assign up_idx = bus.upd_pc[IDX_W-1:0];
    assign up_tag = bus.upd_pc[PC_W-1:IDX_W];

    always_comb begin
        lk_hit   = (DYNAMIC != 0) && bus.if_valid && tbl_valid[lk_idx]
                   && (tbl_tag[lk_idx] == lk_tag);
        lk_taken = lk_hit && tbl_ctr[lk_idx][1];
    end

    assign bus.pred_hit   = lk_hit;
    assign bus.pred_taken = lk_taken;
    assign bus.pred_npc   = lk_taken ? tbl_target[lk_idx] : bus.if_pc + PC_W'(1);

    assign up_hit = tbl_valid[up_idx] && (tbl_tag[up_idx] == up_tag);

    always_comb begin
        wr_en     = 1'b0;
        wr_valid  = tbl_valid[up_idx];
        wr_tag    = tbl_tag[up_idx];
        wr_target = tbl_target[up_idx];
        wr_ctr    = tbl_ctr[up_idx];
        if ((DYNAMIC != 0) && bus.upd_valid) begin
            if (bus.upd_is_branch) begin
                if (up_hit) begin
                    wr_en = 1'b1;
                    if (bus.upd_taken) begin
                        wr_target = bus.upd_target;
                        if (tbl_ctr[up_idx] != 2'd3) wr_ctr = tbl_ctr[up_idx] + 2'd1;
                    end else if (tbl_ctr[up_idx] != 2'd0) begin
                        wr_ctr = tbl_ctr[up_idx] - 2'd1;
                    end
                end else if (bus.upd_taken) begin
                    // Allocation silently evicts whatever aliases onto this index.
                    wr_en     = 1'b1;
                    wr_valid  = 1'b1;
                    wr_tag    = up_tag;
                    wr_target = bus.upd_target;
                    wr_ctr    = 2'd2;
                end
            end else if (up_hit) begin
                wr_en    = 1'b1;
                wr_valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_valid[i]  <= 1'b0;
                tbl_tag[i]    <= '0;
                tbl_target[i] <= '0;
                tbl_ctr[i]    <= 2'd1;
            end
        end else if (wr_en) begin
            tbl_valid[up_idx]  <= wr_valid;
            tbl_tag[up_idx]    <= wr_tag;
            tbl_target[up_idx] <= wr_target;
            tbl_ctr[up_idx]    <= wr_ctr;
        end
    end

    // A single next-PC compare covers both wrong-direction and wrong-target cases.
    assign cnpc = (bus.upd_is_branch && bus.upd_taken) ? bus.upd_target
                                                       : bus.upd_pc + PC_W'(1);
    assign mis  = bus.upd_valid && (cnpc != bus.upd_pred_npc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_q    <= 1'b0;
            redirect_q <= '0;
            lookups_q  <= '0;
            mispred_q  <= '0;
        end else begin
            flush_q <= mis;
            if (mis) redirect_q <= cnpc;
            if (bus.if_valid && (lookups_q != '1)) lookups_q <= lookups_q + STAT_W'(1);
            if (mis && (mispred_q != '1)) mispred_q <= mispred_q + STAT_W'(1);
        end
    end

    assign bus.flush        = flush_q;
    assign bus.redirect_pc  = redirect_q;
    assign bus.stat_lookups = lookups_q;
    assign bus.stat_mispred = mispred_q;
endmodule

// File: tb/tb_branch_predict_btb.sv
// Scoreboard bench: a dynamic and a static-not-taken BTB driven with the same stimulus,
// checked against a keyed-table reference model.
module tb_branch_predict_btb;
    localparam int PC_W = 30;
    localparam int NSLOT = 16;

    typedef struct {
        logic            hit;
        logic            taken;
        logic [PC_W-1:0] npc;
    } pred_t;

    typedef struct {
        int              cyc;
        logic [PC_W-1:0] pc;
    } fl_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    branch_predict_btb_if #(.PC_W(PC_W), .STAT_W(16)) bus_d ();
    branch_predict_btb_if #(.PC_W(PC_W), .STAT_W(16)) bus_s ();

    branch_predict_btb #(.ENTRIES(16), .PC_W(PC_W), .DYNAMIC(1), .STAT_W(16))
        dut_d (.clk(clk), .rst(rst), .bus(bus_d.slave));
    branch_predict_btb #(.ENTRIES(16), .PC_W(PC_W), .DYNAMIC(0), .STAT_W(16))
        dut_s (.clk(clk), .rst(rst), .bus(bus_s.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference model: each slot remembers the full PC it was allocated for.
    logic            m_valid [NSLOT];
    logic [PC_W-1:0] m_key   [NSLOT];
    logic [PC_W-1:0] m_tgt   [NSLOT];
    int              m_ctr   [NSLOT];
    int              n_lk = 0;
    int              n_mis = 0;

    pred_t pq_d[$];
    pred_t pq_s[$];
    fl_t   fq_d[$];
    fl_t   fq_s[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic pred_t model_pred(input logic [PC_W-1:0] pc);
        pred_t p;
        int s;
        s = int'(pc % NSLOT);
        p.hit   = m_valid[s] && (m_key[s] == pc);
        p.taken = p.hit && (m_ctr[s] >= 2);
        p.npc   = p.taken ? m_tgt[s] : pc + 30'd1;
        return p;
    endfunction

    function automatic logic [31:0] sat16(input int n);
        return (n > 65535) ? 32'd65535 : 32'(n);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NSLOT; i++) begin
            m_valid[i] = 1'b0;
            m_key[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        n_lk  = 0;
        n_mis = 0;
    endtask

    task automatic drive(input logic iv, input logic [PC_W-1:0] ipc, input logic uv,
                         input logic br, input logic [PC_W-1:0] upc, input logic tk,
                         input logic [PC_W-1:0] tgt, input logic ptk,
                         input logic [PC_W-1:0] pnpc);
        bus_d.if_valid = iv;  bus_d.if_pc = ipc;  bus_d.upd_valid = uv;
        bus_d.upd_is_branch = br;  bus_d.upd_pc = upc;  bus_d.upd_taken = tk;
        bus_d.upd_target = tgt;  bus_d.upd_pred_taken = ptk;  bus_d.upd_pred_npc = pnpc;
        bus_s.if_valid = iv;  bus_s.if_pc = ipc;  bus_s.upd_valid = uv;
        bus_s.upd_is_branch = br;  bus_s.upd_pc = upc;  bus_s.upd_taken = tk;
        bus_s.upd_target = tgt;  bus_s.upd_pred_taken = ptk;  bus_s.upd_pred_npc = pnpc;
    endtask

    // One pipeline cycle: check registered stats, drive, queue expectations, advance the model.
    task automatic step(input logic iv, input logic [PC_W-1:0] ipc, input logic uv,
                        input logic br, input logic [PC_W-1:0] upc, input logic tk,
                        input logic [PC_W-1:0] tgt, input logic ptk,
                        input logic [PC_W-1:0] pnpc);
        pred_t p;
        fl_t f;
        logic [PC_W-1:0] cn;
        int s;
        @(posedge clk);
        #1;
        chk("stat_lookups_dyn", 32'(bus_d.stat_lookups), sat16(n_lk));
        chk("stat_mispred_dyn", 32'(bus_d.stat_mispred), sat16(n_mis));
        chk("stat_lookups_static", 32'(bus_s.stat_lookups), sat16(n_lk));
        chk("stat_mispred_static", 32'(bus_s.stat_mispred), sat16(n_mis));
        drive(iv, ipc, uv, br, upc, tk, tgt, ptk, pnpc);
        if (iv) begin
            pq_d.push_back(model_pred(ipc));
            p.hit = 1'b0; p.taken = 1'b0; p.npc = ipc + 30'd1;
            pq_s.push_back(p);
            n_lk++;
        end
        if (uv) begin
            cn = (br && tk) ? tgt : upc + 30'd1;
            if (cn != pnpc) begin
                f.cyc = cyc + 1;
                f.pc  = cn;
                fq_d.push_back(f);
                fq_s.push_back(f);
                n_mis++;
            end
            p = model_pred(upc);
            s = int'(upc % NSLOT);
            if (br) begin
                if (p.hit) begin
                    m_ctr[s] = tk ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3)
                                  : ((m_ctr[s] > 0) ? m_ctr[s] - 1 : 0);
                    if (tk) m_tgt[s] = tgt;
                end else if (tk) begin
                    m_valid[s] = 1'b1;
                    m_key[s]   = upc;
                    m_tgt[s]   = tgt;
                    m_ctr[s]   = 2;
                end
            end else if (p.hit) begin
                m_valid[s] = 1'b0;
            end
        end
    endtask

    task automatic look(input logic [PC_W-1:0] pc);
        step(1'b1, pc, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    // Resolution report carrying whatever the model would have predicted for that PC.
    task automatic resolve(input logic br, input logic [PC_W-1:0] pc, input logic tk,
                           input logic [PC_W-1:0] tgt);
        pred_t p;
        p = model_pred(pc);
        step(1'b0, '0, 1'b1, br, pc, tk, tgt, p.taken, p.npc);
    endtask

    function automatic logic [PC_W-1:0] rand_pc();
        if ($urandom_range(0, 15) == 0) return 30'h3FFF_FFFF;
        return 30'h100 + 30'($urandom_range(0, 40));
    endfunction

    always @(negedge clk) begin
        pred_t e;
        fl_t f;
        if (bus_d.if_valid) begin
            if (pq_d.size() == 0) chk("pred_dyn_unexpected", 32'd1, 32'd0);
            else begin
                e = pq_d.pop_front();
                chk("pred_hit_dyn", 32'(bus_d.pred_hit), 32'(e.hit));
                chk("pred_taken_dyn", 32'(bus_d.pred_taken), 32'(e.taken));
                chk("pred_npc_dyn", 32'(bus_d.pred_npc), 32'(e.npc));
            end
        end
        if (bus_s.if_valid) begin
            if (pq_s.size() == 0) chk("pred_static_unexpected", 32'd1, 32'd0);
            else begin
                e = pq_s.pop_front();
                chk("pred_hit_static", 32'(bus_s.pred_hit), 32'(e.hit));
                chk("pred_taken_static", 32'(bus_s.pred_taken), 32'(e.taken));
                chk("pred_npc_static", 32'(bus_s.pred_npc), 32'(e.npc));
            end
        end
        if (bus_d.flush) begin
            if (fq_d.size() == 0) chk("flush_dyn_unexpected", 32'd1, 32'd0);
            else begin
                f = fq_d.pop_front();
                chk("flush_cycle_dyn", 32'(cyc), 32'(f.cyc));
                chk("redirect_pc_dyn", 32'(bus_d.redirect_pc), 32'(f.pc));
            end
        end
        if (bus_s.flush) begin
            if (fq_s.size() == 0) chk("flush_static_unexpected", 32'd1, 32'd0);
            else begin
                f = fq_s.pop_front();
                chk("flush_cycle_static", 32'(cyc), 32'(f.cyc));
                chk("redirect_pc_static", 32'(bus_s.redirect_pc), 32'(f.pc));
            end
        end
    end

    initial begin
        pred_t p;
        logic iv, uv, br, tk;
        logic [PC_W-1:0] ipc, upc, tgt, cn, pnpc;
        int mode;

        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        model_reset();
        #22;
        chk("reset_flush", 32'(bus_d.flush), 32'd0);
        chk("reset_redirect", 32'(bus_d.redirect_pc), 32'd0);
        rst = 1'b1;

        look(30'h100);
        step(1'b0, '0, 1'b1, 1'b1, 30'h100, 1'b1, 30'h200, 1'b0, 30'h101);
        look(30'h100);
        for (int i = 0; i < 4; i++) resolve(1'b1, 30'h100, 1'b0, '0);
        look(30'h100);

        resolve(1'b1, 30'h100, 1'b1, 30'h200);
        step(1'b0, '0, 1'b1, 1'b1, 30'h110, 1'b1, 30'h250, 1'b0, 30'h111);
        look(30'h100);
        look(30'h110);
        step(1'b0, '0, 1'b1, 1'b0, 30'h110, 1'b0, '0, 1'b0, 30'h111);
        look(30'h110);

        step(1'b1, 30'h300, 1'b1, 1'b1, 30'h300, 1'b1, 30'h340, 1'b0, 30'h301);
        look(30'h300);
        look(30'h3FFF_FFFF);

        // Reset asserted while a flush is showing and another mispredict is pending.
        step(1'b0, '0, 1'b1, 1'b1, 30'h500, 1'b1, 30'h600, 1'b0, 30'h501);
        step(1'b0, '0, 1'b1, 1'b1, 30'h510, 1'b1, 30'h610, 1'b0, 30'h511);
        @(negedge clk);
        #2;
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        rst = 1'b0;
        #1;
        chk("async_reset_flush_dyn", 32'(bus_d.flush), 32'd0);
        chk("async_reset_flush_static", 32'(bus_s.flush), 32'd0);
        chk("async_reset_redirect", 32'(bus_d.redirect_pc), 32'd0);
        chk("async_reset_mispred", 32'(bus_d.stat_mispred), 32'd0);
        fq_d.delete();
        fq_s.delete();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        look(30'h500);
        look(30'h100);

        for (int n = 0; n < 1500; n++) begin
            iv  = ($urandom_range(0, 3) != 0);
            ipc = rand_pc();
            uv  = ($urandom_range(0, 2) != 0);
            upc = rand_pc();
            br  = ($urandom_range(0, 3) != 0);
            tk  = 1'($urandom_range(0, 1));
            tgt = 30'h200 + 30'($urandom_range(0, 63));
            cn  = (br && tk) ? tgt : upc + 30'd1;
            p   = model_pred(upc);
            mode = int'($urandom_range(0, 3));
            pnpc = (mode == 1) ? cn : (mode == 2) ? 30'($urandom_range(0, 1023)) : p.npc;
            step(iv, ipc, uv, br, upc, tk, tgt, p.taken, pnpc);
        end

        for (int n = 0; n < 65600; n++)
            step(1'b1, 30'h40, 1'b1, 1'b1, 30'h40, 1'b1, 30'h200, 1'b0, 30'h41);

        repeat (3) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        chk("stat_mispred_saturated_static", 32'(bus_s.stat_mispred), 32'h0000_FFFF);
        chk("stat_lookups_saturated_dyn", 32'(bus_d.stat_lookups), 32'h0000_FFFF);
        chk("flush_queue_drained_dyn", 32'(fq_d.size()), 32'd0);
        chk("flush_queue_drained_static", 32'(fq_s.size()), 32'd0);
        chk("pred_queue_drained_dyn", 32'(pq_d.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
